// File: rtl/stitch_pipeline_hs.sv
// Stitched add-per-stage pipeline with valid/ready handshake, bubble collapsing,
// synchronous flush and an occupancy counter.
module stitch_pipeline_hs #(
  parameter int               WIDTH      = 32,
  parameter int               NUM_STAGES = 2,
  parameter logic [WIDTH-1:0] STAGE_ADD  = {WIDTH{1'b0}}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(NUM_STAGES + 1);

  logic [WIDTH-1:0]      r_data [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_valid;
  logic [OCC_W-1:0]      r_occ;

  logic [NUM_STAGES-1:0] w_adv;
  logic [NUM_STAGES-1:0] w_valid_nxt;
  logic [OCC_W-1:0]      w_occ_nxt;
  logic                  w_in_acc;
  logic                  w_out_acc;

  // Advance chain: a stage moves if the consumer drains or any stage at or after it is empty.
  always_comb begin : adv_chain
    logic l_chain;
    l_chain = out_ready;
    w_adv   = {NUM_STAGES{1'b0}};
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      l_chain  = l_chain || !r_valid[k];
      w_adv[k] = l_chain;
    end
  end

  // Handshake qualifiers seen by the producer and the consumer.
  always_comb begin
    in_ready  = w_adv[0] && !flush && !rst;
    w_in_acc  = in_valid && in_ready;
    w_out_acc = r_valid[NUM_STAGES-1] && out_ready;
  end

  // Next valid bits: flush empties every stage, otherwise advancing stages take their predecessor.
  always_comb begin
    w_valid_nxt = r_valid;
    if (flush) begin
      w_valid_nxt = {NUM_STAGES{1'b0}};
    end else begin
      if (w_adv[0]) begin
        w_valid_nxt[0] = w_in_acc;
      end else begin
        w_valid_nxt[0] = r_valid[0];
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (w_adv[k]) begin
          w_valid_nxt[k] = r_valid[k-1];
        end else begin
          w_valid_nxt[k] = r_valid[k];
        end
      end
    end
  end

  // Occupancy tracks accepts minus drains; a simultaneous pair leaves it unchanged.
  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = {OCC_W{1'b0}};
    end else begin
      case ({w_in_acc, w_out_acc})
        2'b10:   w_occ_nxt = r_occ + OCC_W'(1'b1);
        2'b01:   w_occ_nxt = r_occ - OCC_W'(1'b1);
        default: w_occ_nxt = r_occ;
      endcase
    end
  end

  // Stage registers; data is never cleared by flush, only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_data[k] <= {WIDTH{1'b0}};
      end
      r_valid <= {NUM_STAGES{1'b0}};
      r_occ   <= {OCC_W{1'b0}};
    end else begin
      if (w_adv[0]) begin
        r_data[0] <= in_data + STAGE_ADD;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (w_adv[k]) begin
          r_data[k] <= r_data[k-1] + STAGE_ADD;
        end
      end
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  assign out_valid = r_valid[NUM_STAGES-1];
  assign out_data  = r_data[NUM_STAGES-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_stitch_pipeline_hs.sv
// Scoreboard bench for stitch_pipeline_hs using four differently parameterised instances.
module tb_stitch_pipeline_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u0: N=3, ADD=5 (latency, flush)
  logic f0, iv0, ir0, ov0, or0;
  logic [31:0] id0, od0;
  logic [1:0]  oc0;
  // u1: N=2, ADD=0 (reset, stream)
  logic f1, iv1, ir1, ov1, or1;
  logic [31:0] id1, od1;
  logic [1:0]  oc1;
  // u2: N=4, ADD=0x11 (stall fill)
  logic f2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [2:0]  oc2;
  // u3: WIDTH=8, N=2, ADD=0xF0 (wrap)
  logic f3, iv3, ir3, ov3, or3;
  logic [7:0]  id3, od3;
  logic [1:0]  oc3;

  stitch_pipeline_hs #(.WIDTH(32), .NUM_STAGES(3), .STAGE_ADD(32'd5)) u0 (
    .clk(clk), .rst(rst), .flush(f0), .in_data(id0), .in_valid(iv0), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_ready(or0), .occupancy(oc0));
  stitch_pipeline_hs #(.WIDTH(32), .NUM_STAGES(2), .STAGE_ADD(32'd0)) u1 (
    .clk(clk), .rst(rst), .flush(f1), .in_data(id1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1), .occupancy(oc1));
  stitch_pipeline_hs #(.WIDTH(32), .NUM_STAGES(4), .STAGE_ADD(32'h11)) u2 (
    .clk(clk), .rst(rst), .flush(f2), .in_data(id2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2), .occupancy(oc2));
  stitch_pipeline_hs #(.WIDTH(8), .NUM_STAGES(2), .STAGE_ADD(8'hF0)) u3 (
    .clk(clk), .rst(rst), .flush(f3), .in_data(id3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .occupancy(oc3));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sbq [4][$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pop/compare on an output handshake, push the reference on an input handshake.
  task automatic sb_step(input int id, input logic acc_in, input logic [31:0] exp_in,
                         input logic acc_out, input logic [31:0] obs_out);
    logic [31:0] e;
    if (acc_out) begin
      if (sbq[id].size() == 0) begin
        check_value($sformatf("sb%0d_unexpected_out", id), obs_out, 32'hDEAD_BEEF);
      end else begin
        e = sbq[id].pop_front();
        check_value($sformatf("sb%0d_data", id), obs_out, e);
      end
    end
    if (acc_in) sbq[id].push_back(exp_in);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      sb_step(0, iv0 && ir0, id0 + 32'd15, ov0 && or0, od0);
      sb_step(1, iv1 && ir1, id1, ov1 && or1, od1);
      sb_step(2, iv2 && ir2, id2 + 32'h44, ov2 && or2, od2);
      sb_step(3, iv3 && ir3, {24'd0, 8'(id3 + 8'hE0)}, ov3 && or3, {24'd0, od3});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    {f0, f1, f2, f3} = 4'b0000;
    {iv0, iv1, iv2, iv3} = 4'b1111;
    {or0, or1, or2, or3} = 4'b1111;
    id0 = 32'd7; id1 = 32'd7; id2 = 32'd7; id3 = 8'd7;

    // Reset held across two edges with traffic offered
    @(negedge clk);
    check_value("rst_out_valid", {31'd0, ov1}, 32'd0);
    check_value("rst_out_data", od1, 32'd0);
    check_value("rst_occ", {30'd0, oc1}, 32'd0);
    check_value("rst_in_ready", {31'd0, ir1}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    {iv0, iv1, iv2, iv3} = 4'b0000;
    @(negedge clk);
    check_value("post_rst_in_ready", {31'd0, ir1}, 32'd1);
    check_value("post_rst_occ", {30'd0, oc1}, 32'd0);
    check_value("post_rst_out_valid", {31'd0, ov1}, 32'd0);

    // Latency on u0
    tick();
    id0 = 32'd10; iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov0 && lat < 10);
    check_value("lat_cycles", lat, 32'd3);
    check_value("lat_data", od0, 32'd25);
    @(negedge clk);
    check_value("lat_single_beat", {31'd0, ov0}, 32'd0);

    // Back-to-back stream on u1
    tick();
    for (int i = 1; i <= 8; i++) begin
      id1 = i; iv1 = 1'b1;
      @(negedge clk);
      check_value("stream_in_ready", {31'd0, ir1}, 32'd1);
      check_value("stream_occ", {30'd0, oc1}, (i - 1 > 2) ? 32'd2 : i - 1);
      if (i >= 3) check_value("stream_out_valid", {31'd0, ov1}, 32'd1);
      tick();
    end
    iv1 = 1'b0;
    repeat (4) tick();
    check_value("stream_drained", sbq[1].size(), 32'd0);

    // Stall fill then steady flow on u2
    or2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id2 = 32'd100 + i; iv2 = 1'b1;
      @(negedge clk);
      check_value("fill_occ", {29'd0, oc2}, i);
      check_value("fill_in_ready", {31'd0, ir2}, 32'd1);
      tick();
    end
    id2 = 32'd104;
    @(negedge clk);
    check_value("full_occ", {29'd0, oc2}, 32'd4);
    check_value("full_in_ready", {31'd0, ir2}, 32'd0);
    tick();
    or2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id2 = 32'd104 + i;
      @(negedge clk);
      check_value("flow_in_ready", {31'd0, ir2}, 32'd1);
      check_value("flow_out_valid", {31'd0, ov2}, 32'd1);
      check_value("flow_occ", {29'd0, oc2}, 32'd4);
      tick();
    end
    iv2 = 1'b0;
    repeat (6) tick();
    check_value("flow_drained", sbq[2].size(), 32'd0);
    @(negedge clk);
    check_value("flow_empty_occ", {29'd0, oc2}, 32'd0);

    // Flush with two words held on u0
    tick();
    or0 = 1'b0;
    id0 = 32'd50; iv0 = 1'b1;
    tick();
    id0 = 32'd51;
    tick();
    f0 = 1'b1; id0 = 32'd99;
    @(negedge clk);
    check_value("flush_in_ready", {31'd0, ir0}, 32'd0);
    check_value("pre_flush_occ", {30'd0, oc0}, 32'd2);
    tick();
    f0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    sbq[0].delete();
    @(negedge clk);
    check_value("post_flush_occ", {30'd0, oc0}, 32'd0);
    check_value("post_flush_valid", {31'd0, ov0}, 32'd0);
    repeat (5) tick();

    // Modulo wrap on u3
    id3 = 8'h30; iv3 = 1'b1;
    tick();
    iv3 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov3 && lat < 10);
    check_value("wrap_valid", {31'd0, ov3}, 32'd1);
    check_value("wrap_data", {24'd0, od3}, 32'h10);
    tick();
    tick();
    check_value("wrap_drained", sbq[3].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stitch_pipeline_hs.md
# stitch_pipeline_hs

Parametrised stitched pipeline with a valid/ready handshake. It is the successor to the fixed-latency, free-running stitched pipeline wrapper. It chains NUM_STAGES registered stages, and each stage adds a constant to the word passing through. Compared with the free-running wrapper, it adds:
- per-stage valid bits
- backpressure with bubble collapsing
- a synchronous flush
- an occupancy count

It sits between a producer and a consumer that both use valid/ready.

## Interface
Parameters:
- WIDTH, default 32: data word width in bits, ≥ 1.
- NUM_STAGES, default 2: number of pipeline registers, ≥ 1.
- STAGE_ADD, default 0: per-stage addend, WIDTH bits. With the value 0 the block is a pure registered pass-through.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all in-flight words.
- in_data  in  WIDTH  producer word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  WIDTH  word at the last stage.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- occupancy  out  $clog2(NUM_STAGES+1)  number of valid words held, range 0..NUM_STAGES.

## Operation
- **Storage.** Stage registers d[1..N] and valid bits v[1..N], where N = NUM_STAGES.
- **Stage function.** d[1] captures in_data + STAGE_ADD. d[k] captures d[k-1] + STAGE_ADD.
  - Each add is modulo 2^WIDTH; the carry-out is discarded.
  - A word leaving the block equals in_data + N·STAGE_ADD mod 2^WIDTH.
- **Advance condition**, combinational from the last stage backwards:
  - adv[N] = !v[N] || out_ready
  - adv[k] = !v[k] || adv[k+1]
  - A stage loads from its predecessor when adv[k] is high.
  - v[k] takes v[k-1], or in_valid && in_ready for k = 1.
- **Bubble collapse.** An empty stage always loads, even while downstream is stalled. A stalled pipeline therefore fills to N words.
- **Data hold.** Data registers hold their value when the stage does not advance.
- **Ready and valid outputs.**
  - in_ready = adv[1] && !flush && !rst.
  - out_valid = v[N]; out_data = d[N].
  - out_data is driven even when out_valid is low; it holds the last loaded value.
- **Occupancy.** A register that adds 1 on an input accept (in_valid && in_ready) and subtracts 1 on an output accept (out_valid && out_ready).
  - Simultaneous accept and drain leaves it unchanged.
  - It always equals popcount(v).
- **Flush.** Clears all v[k] and sets occupancy to 0 on the next edge.
  - Data registers are not cleared.
  - in_ready is low during flush, so no word is accepted in a flush cycle.
  - An output handshake in the flush cycle still counts as a transfer to the consumer.
- **Reset.**
  - All v[k] = 0, all d[k] = 0, occupancy = 0.
  - Therefore out_valid = 0, out_data = 0 and in_ready = 0 while rst is high.
  - rst has priority over flush and all handshakes.

## Timing
- **Latency.** A word accepted at edge t, with no stall, is presented with out_valid high in the cycle after edge t+N-1. That is N cycles from acceptance to visibility, with one register per stage.
- **Throughput.** One word per cycle when out_ready is held high.
- **Ready path.** in_ready depends combinationally on out_ready through the adv chain. out_valid and out_data are registered.
- **Full pipeline** (occupancy = N):
  - in_ready = out_ready.
  - Accept and drain in the same cycle are legal, and occupancy stays at N.
- **Empty pipeline.** in_ready = 1, except during flush or rst.
- **First cycle after reset deasserts.** in_ready = 1.

## Test plan
- **Reset.** Hold rst for 2 cycles with in_valid = 1 and out_ready = 1.
  - Required: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 0, and no word is accepted.
- **Latency.** N = 3, STAGE_ADD = 5. Send in_data = 10 for one cycle with out_ready = 1.
  - Required: out_valid rises exactly 3 cycles after acceptance, with out_data = 25, and stays high for exactly 1 cycle.
- **Stream.** N = 2, STAGE_ADD = 0. Stream 1..8 back-to-back with out_ready = 1.
  - Required: outputs 1..8 on consecutive cycles, in_ready high throughout, occupancy steady at 2.
- **Stall fill.**
  - N = 4. Hold out_ready = 0 and offer 4 words.
    - Required: occupancy counts 1, 2, 3, 4, and in_ready drops when occupancy reaches 4.
  - Then raise out_ready with in_valid still high.
    - Required: one word in and one word out per cycle, occupancy stays at 4, and order is preserved.
- **Flush mid-flight.** N = 3, 2 words held. Assert flush for 1 cycle with in_valid = 1.
  - Required: in_ready = 0 in the flush cycle, the next cycle shows occupancy = 0 and out_valid = 0, and the offered word is not accepted.
- **Wrap-around.** WIDTH = 8, N = 2, STAGE_ADD = 8'hF0, in_data = 8'h30.
  - Required: out_data = 8'h10.
